// File: rtl/ariane_pkg.sv
// Branch-resolution and predictor-training types for the CVA6 frontend.
package ariane_pkg;

  localparam int unsigned VLEN = 64;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic                     valid;
    logic [VLEN-1:0]          pc;
    cva6_cheri_pkg::cap_pcc_t target_address;
    logic                     is_mispredict;
    logic                     is_taken;
    cf_t                      cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic [VLEN-1:0] target_address;
  } btb_update_t;

endpackage

// File: rtl/cva6_cheri_pkg.sv
// CHERI capability types shared by the CVA6 fetch-redirect path.
package cva6_cheri_pkg;

  typedef struct packed {
    logic        tag;
    logic [11:0] perms;
    logic [63:0] base;
    logic [63:0] top;
    logic [63:0] addr;
  } cap_pcc_t;

  localparam cap_pcc_t PCC_NULL_CAP = '{tag: 1'b0, perms: '0, base: '0, top: '0, addr: '0};

  typedef enum logic {
    IDLE,
    REDIRECT
  } redirect_state_e;

endpackage

// File: rtl/cheri_pcc_redirect_unit.sv
// Turns resolved mispredicts into a held PCC fetch redirect, a one-cycle
// unissued-kill pulse, BHT/BTB training pulses and a saturating mispredict count.
module cheri_pcc_redirect_unit
  import ariane_pkg::*;
  import cva6_cheri_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  bp_resolve_t resolved_branch_i,
  input  logic        flush_i,
  input  logic        redirect_ready_i,
  output logic        redirect_valid_o,
  output cap_pcc_t    redirect_pcc_o,
  output logic        flush_unissued_o,
  output bht_update_t bht_update_o,
  output btb_update_t btb_update_o,
  output logic [31:0] mispredict_cnt_o
);

  redirect_state_e state_q, state_d;
  cap_pcc_t        pcc_q, pcc_d;
  logic            flush_unissued_q;
  bht_update_t     bht_q;
  btb_update_t     btb_q;
  logic [31:0]     mispredict_cnt_q;

  logic accept;
  logic bht_fire;
  logic btb_fire;

  always_comb begin
    accept   = resolved_branch_i.valid && resolved_branch_i.is_mispredict && !flush_i;
    bht_fire = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch) && !flush_i;
    btb_fire = resolved_branch_i.valid && resolved_branch_i.is_mispredict
               && (resolved_branch_i.cf_type == JumpR) && !flush_i;
  end

  // Flush beats a new mispredict, which in turn beats the frontend accepting
  // the old redirect (latest target wins even on the handshake cycle).
  always_comb begin
    state_d = state_q;
    pcc_d   = pcc_q;
    if (flush_i) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = REDIRECT;
      pcc_d   = resolved_branch_i.target_address;
    end else if (state_q == REDIRECT && redirect_ready_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      pcc_q            <= PCC_NULL_CAP;
      flush_unissued_q <= 1'b0;
      bht_q            <= '0;
      btb_q            <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q                  <= state_d;
      pcc_q                    <= pcc_d;
      flush_unissued_q         <= accept;
      bht_q.valid              <= bht_fire;
      bht_q.pc                 <= resolved_branch_i.pc;
      bht_q.taken              <= resolved_branch_i.is_taken;
      btb_q.valid              <= btb_fire;
      btb_q.pc                 <= resolved_branch_i.pc;
      btb_q.target_address     <= resolved_branch_i.target_address.addr;
      if (accept && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pcc_o   = pcc_q;
  assign flush_unissued_o = flush_unissued_q;
  assign bht_update_o     = bht_q;
  assign btb_update_o     = btb_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_cheri_pcc_redirect_unit.sv
// Directed and randomized checks of the PCC redirect unit against a cycle-level reference model.
module tb_cheri_pcc_redirect_unit;
  import ariane_pkg::*;
  import cva6_cheri_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  bp_resolve_t rb;
  logic        flush;
  logic        ready;
  logic        redirect_valid_o;
  cap_pcc_t    redirect_pcc_o;
  logic        flush_unissued_o;
  bht_update_t bht_update_o;
  btb_update_t btb_update_o;
  logic [31:0] mispredict_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: what the outputs must show after the next edge
  logic        m_pending;
  cap_pcc_t    m_pcc;
  logic        m_flush;
  bht_update_t m_bht;
  btb_update_t m_btb;
  longint      m_cnt;

  cheri_pcc_redirect_unit dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .resolved_branch_i (rb),
    .flush_i           (flush),
    .redirect_ready_i  (ready),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pcc_o    (redirect_pcc_o),
    .flush_unissued_o  (flush_unissued_o),
    .bht_update_o      (bht_update_o),
    .btb_update_o      (btb_update_o),
    .mispredict_cnt_o  (mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic cap_pcc_t mk_cap(logic tag, logic [63:0] addr);
    cap_pcc_t c;
    c       = '0;
    c.tag   = tag;
    c.perms = 12'h0A5;
    c.base  = 64'h8000_0000;
    c.top   = 64'h8001_0000;
    c.addr  = addr;
    return c;
  endfunction

  function automatic bp_resolve_t mk_rb(logic v, logic [63:0] pc, cap_pcc_t tgt,
                                        logic mis, logic taken, cf_t cf);
    bp_resolve_t r;
    r.valid          = v;
    r.pc             = pc;
    r.target_address = tgt;
    r.is_mispredict  = mis;
    r.is_taken       = taken;
    r.cf_type        = cf;
    return r;
  endfunction

  task automatic idle_inputs();
    rb    = '0;
    flush = 1'b0;
    ready = 1'b0;
  endtask

  // Advance one clock; the model applies the rules to the inputs seen at the edge.
  task automatic tick();
    logic acc;
    if (!rst_n) begin
      m_pending = 1'b0;
      m_pcc     = '0;
      m_flush   = 1'b0;
      m_bht     = '0;
      m_btb     = '0;
      m_cnt     = 0;
    end else begin
      acc                  = rb.valid && rb.is_mispredict && !flush;
      m_flush              = acc;
      m_bht.valid          = rb.valid && (rb.cf_type == Branch) && !flush;
      m_bht.pc             = rb.pc;
      m_bht.taken          = rb.is_taken;
      m_btb.valid          = rb.valid && rb.is_mispredict && (rb.cf_type == JumpR) && !flush;
      m_btb.pc             = rb.pc;
      m_btb.target_address = rb.target_address.addr;
      if (acc && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) m_pending = 1'b0;
      else if (acc) begin
        m_pending = 1'b1;
        m_pcc     = rb.target_address;
      end else if (ready) m_pending = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rb    = mk_rb(1'b1, 64'h40, mk_cap(1'b1, 64'h8000_0040), 1'b1, 1'b1, Branch);
    flush = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    n_checks++; if (redirect_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", redirect_valid_o); else n_pass++;
    n_checks++; if (flush_unissued_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_unissued_o); else n_pass++;
    n_checks++; if (bht_update_o.valid !== 1'b0) $display("FAIL reset_bht: got %b want 0", bht_update_o.valid); else n_pass++;
    n_checks++; if (btb_update_o.valid !== 1'b0) $display("FAIL reset_btb: got %b want 0", btb_update_o.valid); else n_pass++;
    n_checks++; if (mispredict_cnt_o !== 32'd0) $display("FAIL reset_cnt: got %h want 0", mispredict_cnt_o); else n_pass++;
    n_checks++; if (redirect_pcc_o.tag !== 1'b0 || redirect_pcc_o.addr !== 64'd0)
      $display("FAIL reset_pcc: got tag %b addr %h want tag 0 addr 0", redirect_pcc_o.tag, redirect_pcc_o.addr); else n_pass++;
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_hold();
    apply_reset();
    rb = mk_rb(1'b1, 64'h1000, mk_cap(1'b1, 64'h8000_1000), 1'b1, 1'b0, Jump);
    tick();
    rb = '0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (redirect_valid_o !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, redirect_valid_o); else n_pass++;
      n_checks++; if (redirect_pcc_o.addr !== 64'h8000_1000 || redirect_pcc_o.tag !== 1'b1)
        $display("FAIL hold_pcc[%0d]: got tag %b addr %h want tag 1 addr 80001000", i, redirect_pcc_o.tag, redirect_pcc_o.addr); else n_pass++;
      n_checks++; if (flush_unissued_o !== (i == 0)) $display("FAIL hold_flush[%0d]: got %b want %b", i, flush_unissued_o, i == 0); else n_pass++;
      ready = (i == 3);
      tick();
    end
    n_checks++; if (redirect_valid_o !== 1'b0) $display("FAIL hold_release: got %b want 0", redirect_valid_o); else n_pass++;
    n_checks++; if (mispredict_cnt_o !== 32'd1) $display("FAIL hold_cnt: got %h want 1", mispredict_cnt_o); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_latest_wins();
    apply_reset();
    rb = mk_rb(1'b1, 64'h1000, mk_cap(1'b1, 64'h8000_1000), 1'b1, 1'b0, Jump);
    tick();
    rb = mk_rb(1'b1, 64'h2000, mk_cap(1'b1, 64'h8000_2000), 1'b1, 1'b1, Branch);
    tick();
    n_checks++; if (redirect_pcc_o.addr !== 64'h8000_2000) $display("FAIL latest_addr: got %h want 80002000", redirect_pcc_o.addr); else n_pass++;
    n_checks++; if (flush_unissued_o !== 1'b1) $display("FAIL latest_flush: got %b want 1", flush_unissued_o); else n_pass++;
    n_checks++; if (mispredict_cnt_o !== 32'd2) $display("FAIL latest_cnt: got %h want 2", mispredict_cnt_o); else n_pass++;
    rb    = mk_rb(1'b1, 64'h3000, mk_cap(1'b0, 64'hDEAD_0000), 1'b1, 1'b0, Return);
    ready = 1'b1;
    tick();
    n_checks++; if (redirect_valid_o !== 1'b1 || redirect_pcc_o.addr !== 64'hDEAD_0000 || redirect_pcc_o.tag !== 1'b0)
      $display("FAIL ready_and_new: got valid %b tag %b addr %h want valid 1 tag 0 addr dead0000",
               redirect_valid_o, redirect_pcc_o.tag, redirect_pcc_o.addr); else n_pass++;
    rb = '0;
    tick();
    n_checks++; if (redirect_valid_o !== 1'b0) $display("FAIL latest_release: got %b want 0", redirect_valid_o); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_flush();
    apply_reset();
    rb    = mk_rb(1'b1, 64'h1000, mk_cap(1'b1, 64'h8000_1000), 1'b1, 1'b0, JumpR);
    flush = 1'b1;
    tick();
    n_checks++; if (redirect_valid_o !== 1'b0 || flush_unissued_o !== 1'b0 || mispredict_cnt_o !== 32'd0 || btb_update_o.valid !== 1'b0)
      $display("FAIL flush_drop: got valid %b pulse %b cnt %h btb %b want 0 0 0 0",
               redirect_valid_o, flush_unissued_o, mispredict_cnt_o, btb_update_o.valid); else n_pass++;
    flush = 1'b0;
    tick();
    n_checks++; if (redirect_valid_o !== 1'b1 || mispredict_cnt_o !== 32'd1)
      $display("FAIL flush_then_accept: got valid %b cnt %h want 1 1", redirect_valid_o, mispredict_cnt_o); else n_pass++;
    rb    = '0;
    flush = 1'b1;
    tick();
    n_checks++; if (redirect_valid_o !== 1'b0) $display("FAIL flush_pending: got %b want 0", redirect_valid_o); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_training();
    apply_reset();
    rb = mk_rb(1'b1, 64'h100, mk_cap(1'b1, 64'h140), 1'b0, 1'b1, Branch);
    tick();
    n_checks++; if (bht_update_o.valid !== 1'b1 || bht_update_o.pc !== 64'h100 || bht_update_o.taken !== 1'b1)
      $display("FAIL bht_train: got v %b pc %h t %b want 1 100 1", bht_update_o.valid, bht_update_o.pc, bht_update_o.taken); else n_pass++;
    n_checks++; if (btb_update_o.valid !== 1'b0 || redirect_valid_o !== 1'b0)
      $display("FAIL bht_side: got btb %b redir %b want 0 0", btb_update_o.valid, redirect_valid_o); else n_pass++;
    rb = mk_rb(1'b1, 64'h104, mk_cap(1'b1, 64'h200), 1'b1, 1'b1, JumpR);
    tick();
    n_checks++; if (btb_update_o.valid !== 1'b1 || btb_update_o.target_address !== 64'h200 || btb_update_o.pc !== 64'h104)
      $display("FAIL btb_train: got v %b pc %h tgt %h want 1 104 200", btb_update_o.valid, btb_update_o.pc, btb_update_o.target_address); else n_pass++;
    n_checks++; if (bht_update_o.valid !== 1'b0) $display("FAIL bht_pulse: got %b want 0", bht_update_o.valid); else n_pass++;
    rb    = mk_rb(1'b1, 64'h108, mk_cap(1'b1, 64'h300), 1'b0, 1'b0, Branch);
    flush = 1'b1;
    tick();
    n_checks++; if (btb_update_o.valid !== 1'b0 || bht_update_o.valid !== 1'b0)
      $display("FAIL train_flush: got btb %b bht %b want 0 0", btb_update_o.valid, bht_update_o.valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_saturation();
    apply_reset();
    force dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_cnt_q;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      rb    = mk_rb(1'b1, 64'h500, mk_cap(1'b1, 64'h8000_5000), 1'b1, 1'b0, Jump);
      ready = 1'b1;
      tick();
      n_checks++; if (mispredict_cnt_o !== 32'hFFFF_FFFF) $display("FAIL sat_cnt[%0d]: got %h want ffffffff", i, mispredict_cnt_o); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_redirect();
    apply_reset();
    rb = mk_rb(1'b1, 64'h600, mk_cap(1'b1, 64'h8000_6000), 1'b1, 1'b0, JumpR);
    tick();
    rst_n = 1'b0;
    rb    = mk_rb(1'b1, 64'h604, mk_cap(1'b1, 64'h8000_7000), 1'b1, 1'b1, Branch);
    tick();
    n_checks++; if (redirect_valid_o !== 1'b0 || flush_unissued_o !== 1'b0 || bht_update_o.valid !== 1'b0
                    || btb_update_o.valid !== 1'b0 || mispredict_cnt_o !== 32'd0)
      $display("FAIL mid_reset: got redir %b pulse %b bht %b btb %b cnt %h want all 0", redirect_valid_o,
               flush_unissued_o, bht_update_o.valid, btb_update_o.valid, mispredict_cnt_o); else n_pass++;
    rst_n = 1'b1;
    idle_inputs();
    tick();
    n_checks++; if (redirect_valid_o !== 1'b0 || flush_unissued_o !== 1'b0)
      $display("FAIL post_reset: got redir %b pulse %b want 0 0", redirect_valid_o, flush_unissued_o); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      rb    = mk_rb($urandom_range(0, 1), {32'd0, $urandom}, mk_cap($urandom_range(0, 1), {$urandom, $urandom}),
                    $urandom_range(0, 1), $urandom_range(0, 1), cf_t'($urandom_range(0, 4)));
      flush = ($urandom_range(0, 9) == 0);
      ready = ($urandom_range(0, 2) == 0);
      tick();
      n_checks++; if (redirect_valid_o !== m_pending) $display("FAIL rnd_valid[%0d]: got %b want %b", i, redirect_valid_o, m_pending); else n_pass++;
      n_checks++; if (redirect_pcc_o !== m_pcc) $display("FAIL rnd_pcc[%0d]: got %h want %h", i, redirect_pcc_o, m_pcc); else n_pass++;
      n_checks++; if (flush_unissued_o !== m_flush) $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_unissued_o, m_flush); else n_pass++;
      n_checks++; if (mispredict_cnt_o !== m_cnt[31:0]) $display("FAIL rnd_cnt[%0d]: got %h want %h", i, mispredict_cnt_o, m_cnt[31:0]); else n_pass++;
      n_checks++; if (bht_update_o.valid !== m_bht.valid || (m_bht.valid && (bht_update_o.pc !== m_bht.pc || bht_update_o.taken !== m_bht.taken)))
        $display("FAIL rnd_bht[%0d]: got %h want %h", i, bht_update_o, m_bht); else n_pass++;
      n_checks++; if (btb_update_o.valid !== m_btb.valid || (m_btb.valid && (btb_update_o.pc !== m_btb.pc || btb_update_o.target_address !== m_btb.target_address)))
        $display("FAIL rnd_btb[%0d]: got %h want %h", i, btb_update_o, m_btb); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_hold();
    test_latest_wins();
    test_flush();
    test_training();
    test_saturation();
    test_reset_mid_redirect();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
